// File: rtl/fft_input_loader_if.sv
// Sample stream into the FFT input loader: valid/ready handshake carrying one
// real sample per beat, with in_last marking the final sample of a frame.
interface fft_input_loader_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/fft_input_loader.sv
// Collects a 16-sample real stream into one parallel frame for a 16-point FFT.
// Define FFT_LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_input_loader #(
  parameter int DATA_W = 32,
  parameter int N_PTS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_input_loader_if.slave       src,
  output logic [DATA_W*N_PTS-1:0] data_real_in_flat,
  output logic                    ready,
  output logic                    frame_err
);

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

  state_t                       state, state_nxt;
  logic [3:0]                   cnt, cnt_nxt;
  logic [3:0]                   slot;
  logic                         accept;
  logic                         load;
  logic                         discard;
  logic [N_PTS-1:0][DATA_W-1:0] fill_buf;
  logic [N_PTS-1:0][DATA_W-1:0] frame_q;
  logic [N_PTS-1:0][DATA_W-1:0] frame_nxt;

  // The single EMIT cycle is the only stall; reset also holds the source off.
  assign src.in_ready = rst && (state != EMIT);
  assign accept       = src.in_valid && src.in_ready;

`ifdef FFT_LOADER_BITREV_EN
  assign slot = {cnt[0], cnt[1], cnt[2], cnt[3]};
`else
  assign slot = cnt;
`endif

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    discard   = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          if (cnt == 4'd15) begin
            cnt_nxt = 4'd0;
            if (src.in_last) begin
              state_nxt = EMIT;
              load      = 1'b1;
            end else begin
              state_nxt = IDLE;
              discard   = 1'b1;
            end
          end else if (src.in_last) begin
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
            discard   = 1'b1;
          end else begin
            cnt_nxt   = cnt + 4'd1;
            state_nxt = FILL;
          end
        end
      end
      EMIT:    state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // The closing sample goes straight into the outgoing frame, not via fill_buf.
  always_comb begin
    frame_nxt       = fill_buf;
    frame_nxt[slot] = src.in_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the sample buffer is cleared too, so nothing from before reset can leak into a frame.
      fill_buf  <= '0;
      frame_q   <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready     <= load;
      frame_err <= discard;
      if (accept && !discard) fill_buf[slot] <= src.in_data;
      if (load) frame_q <= frame_nxt;
    end
  end

  assign data_real_in_flat = frame_q;

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width in bits; only 32 is supported.
REQ-002 SHALL have parameter N_PTS, default 16, frame length in samples; only 16 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_data/in_last are valid this cycle.
REQ-006 SHALL have port in_data  input  32  signed real sample.
REQ-007 SHALL have port in_last  input  1  marks the final sample of a frame.
REQ-008 SHALL have port in_ready  output  1  loader can accept a sample this cycle.
REQ-009 SHALL have port data_real_in_flat  output  512  frame to the 16-point FFT; lane i = bits [32*i+31:32*i].
REQ-010 SHALL have port ready  output  1  one-cycle strobe: data_real_in_flat holds a new frame.
REQ-011 SHALL have port frame_err  output  1  one-cycle strobe: framing error, frame discarded.

Function
REQ-012 SHALL accept a sample only on a rising edge where in_valid=1 and in_ready=1.
REQ-013 SHALL use a 4-bit sample counter cnt that counts accepted samples in the current frame: 0..15.
REQ-014 SHALL implement states IDLE (cnt=0), FILL (0<cnt<=15) and EMIT.
REQ-015 SHALL write accepted sample k, where k=cnt, into fill buffer slot bitrev4(k), e.g. k=1 to slot 8 and k=3 to slot 12.
REQ-016 SHALL move IDLE to FILL on an accept with in_last=0.
REQ-017 SHALL stay in FILL and increment cnt on an accept with cnt<15 and in_last=0.
REQ-018 SHALL, on an accept with cnt=15 and in_last=1, copy the complete fill buffer, including that sample, to the output register, clear cnt, and enter EMIT.
REQ-019 SHALL drive ready=1 and in_ready=0 for exactly one cycle in EMIT, then return to IDLE.
REQ-020 SHALL give latency: 16th accept on edge t gives data_real_in_flat valid and ready=1 from edge t until edge t+1.
REQ-021 SHALL hold data_real_in_flat stable from one EMIT until the next EMIT.
REQ-022 SHALL drive in_ready=1 in IDLE and FILL.
REQ-023 SHALL treat an accept with in_last=1 and cnt<15 as a short frame: frame_err=1 for one cycle, cnt cleared, state IDLE, no ready, output register unchanged.
REQ-024 SHALL treat an accept with cnt=15 and in_last=0 as a long frame: same response as REQ-023.
REQ-025 SHALL leave the fill buffer contents unchanged when a frame is discarded; the next frame overwrites every slot.
REQ-026 SHALL not alter cnt or state on a cycle with in_valid=0, including gaps of any length mid-frame.
REQ-027 SHALL never assert ready and frame_err in the same cycle.
REQ-028 SHALL perform no arithmetic on samples; samples pass bit-exact.

Reset
REQ-029 SHALL, while rst=0 at a rising edge, set state to IDLE, cnt to 0, fill buffer to 0, output register to 0, ready to 0 and frame_err to 0.
REQ-030 SHALL drive in_ready=0 while rst=0.
REQ-031 SHALL, when reset is asserted mid-frame or in EMIT, abandon the partial frame without asserting ready or frame_err.

Configuration
REQ-032 SHALL use macro FFT_LOADER_BITREV_EN: when defined, samples are written at bitrev4(k) per REQ-015.
REQ-033 SHALL, when FFT_LOADER_BITREV_EN is undefined, write sample k at slot k (natural order); all other behaviour is identical.

Verification
REQ-034 SHALL cover: BITREV_EN; feed samples 0..15 with in_last on the 16th -> ready pulses once, one cycle after the 16th accept; lane i = bitrev4(i), e.g. lane 1 = 8 and lane 15 = 15.
REQ-035 SHALL cover: BITREV_EN undefined; same stimulus -> lane i = i.
REQ-036 SHALL cover: in_last on the 5th sample -> frame_err for one cycle, no ready, output bus unchanged; the next 16-sample frame loads correctly.
REQ-037 SHALL cover: 16th sample with in_last=0 -> frame_err for one cycle, no ready.
REQ-038 SHALL cover: back-to-back frames with in_valid held at 1 -> in_ready=0 for exactly one cycle per frame, two ready pulses 17 cycles apart, and the second frame's data is correct.
REQ-039 SHALL cover: rst=0 after 9 samples, then a full frame -> no strobe during reset; a single ready follows with only the new frame's data.
